uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NB, 32, requester word width in bits.
REQ-002 Parameter DATA_BITS, 8, UART byte width; NB SHALL be a multiple of DATA_BITS.
REQ-003 i_clk  in  1  single clock; all state changes on rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-low.
REQ-005 i_req_valid  in  2  per-requester word valid; bit0 = requester 0, bit1 = requester 1.
REQ-006 i_req_last  in  2  per-requester flag marking the word as the final word of its burst.
REQ-007 i_req_data0  in  NB  requester 0 word.
REQ-008 i_req_data1  in  NB  requester 1 word.
REQ-009 o_req_ready  out  2  one-hot, combinational; word accept strobe for the granted requester.
REQ-010 o_grant  out  2  one-hot owner of the UART burst; 0 when no burst is open.
REQ-011 o_uart_tx_data  out  DATA_BITS  byte presented to the UART transmitter.
REQ-012 o_uart_tx_ready  out  1  transmit start; held high until i_uart_tx_done.
REQ-013 i_uart_tx_done  in  1  one-cycle pulse from the transmitter when the byte is sent.
REQ-014 o_busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SEND, WAIT and HOLD.
REQ-016 IDLE: when any i_req_valid is high, the arbiter SHALL select one requester and, in the same cycle, assert its o_req_ready bit.
REQ-017 On the accepting edge, the arbiter SHALL set o_grant, capture the word and its last flag, clear the byte counter and go to SEND.
REQ-018 Selection rule: a lone valid requester wins; when both are valid, the requester named by the round-robin pointer wins.
REQ-019 SEND (one cycle): register the word's upper DATA_BITS into o_uart_tx_data, set o_uart_tx_ready to 1, go to WAIT.
REQ-020 Latency: valid accepted at cycle N; o_uart_tx_ready first reads 1 at N+2, carrying word[NB-1:NB-DATA_BITS].
REQ-021 WAIT: on i_uart_tx_done, set o_uart_tx_ready to 0, shift the word left by DATA_BITS and increment the byte counter.
REQ-022 After a WAIT byte, the next state SHALL be SEND while bytes remain, else the end-of-word state in REQ-023/REQ-024.
REQ-023 End of word with last=1: go to IDLE, clear o_grant, and set the pointer to the requester not just served.
REQ-024 End of word with last=0: go to HOLD with o_grant kept.
REQ-025 HOLD: accept only the granted requester's valid, per REQ-016/REQ-017; the other requester SHALL be ignored (burst lock, no interleaving within a burst).
REQ-026 o_uart_tx_ready SHALL be 0 for exactly one cycle (the SEND cycle) between consecutive bytes.
REQ-027 Byte order: MSB first; NB/DATA_BITS bytes per word; byte counter wraps at NB/DATA_BITS.
REQ-028 i_uart_tx_done outside WAIT SHALL be ignored.
REQ-029 o_req_ready SHALL be 0 in SEND and WAIT and never accepts more than one word per burst slot.
REQ-030 A valid that drops before acceptance SHALL leave no side effects.

Reset
REQ-031 While i_reset=0 at a rising edge, the block SHALL set: state IDLE, o_grant 0, o_uart_tx_data 0, o_uart_tx_ready 0, o_busy 0, byte counter 0, word 0, pointer to requester 0.
REQ-032 Reset mid-byte or mid-burst SHALL discard the burst; o_uart_tx_ready reads 0 on the first cycle after the reset edge.

Structure
REQ-033 State encodings, requester count (2) and bytes-per-word SHALL live in the shared debug constants header, also used by the debug unit.
REQ-034 A single sub-module, tx_word_serializer (SEND/WAIT shift, byte counter, tx handshake), SHALL be instantiated; arbitration and HOLD stay in the top.

Verification
REQ-035 Req0 word 0xDEADBEEF, last=1, done 3 cycles after each ready -> bytes DE, AD, BE, EF; o_req_ready[0] 1 cycle; o_grant returns to 0.
REQ-036 Both valid from reset, each last=1 -> req0 word fully sent first, then req1; o_grant 01 then 10.
REQ-037 Req0 burst of 3 words (last on third) while req1 valid throughout -> 12 bytes from req0 before any req1 byte.
REQ-038 HOLD with req0 valid low for 20 cycles, req1 valid -> no o_req_ready[1]; o_uart_tx_ready stays 0 until req0 resumes.
REQ-039 Reset asserted in WAIT after byte 2 -> o_uart_tx_ready 0 next cycle; later 0x11223344 sends 11 first.
REQ-040 Spurious done in IDLE and SEND -> no counter advance and no byte skipped (checked with 0x01020304).

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared debug constants for the UART transmit arbiter and the debug unit.
// Holds the FSM state encodings, the requester count, the default word
// geometry (bytes per word) and small width helpers.
package uart_tx_arbiter_pkg;

   localparam int unsigned N_REQ             = 2;
   localparam int unsigned NB_DEFAULT        = 32;
   localparam int unsigned DATA_BITS_DEFAULT = 8;
   localparam int unsigned BYTES_PER_WORD    = NB_DEFAULT / DATA_BITS_DEFAULT;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // Bytes carried by one requester word.
   function automatic int unsigned bytes_per_word(input int unsigned nb, input int unsigned db);
      return nb / db;
   endfunction

   // Counter width able to index n items (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / UART handshake bundle for uart_tx_arbiter.
//   slave  : arbiter side (takes requester words and tx_done, drives ready/grant/tx byte)
//   master : environment side (requesters plus UART transmitter)
interface uart_tx_arbiter_if
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NB        = 32,
   parameter int unsigned DATA_BITS = 8
);

   logic [N_REQ-1:0]     i_req_valid;
   logic [N_REQ-1:0]     i_req_last;
   logic [NB-1:0]        i_req_data0;
   logic [NB-1:0]        i_req_data1;
   logic [N_REQ-1:0]     o_req_ready;
   logic [N_REQ-1:0]     o_grant;
   logic [DATA_BITS-1:0] o_uart_tx_data;
   logic                 o_uart_tx_ready;
   logic                 i_uart_tx_done;
   logic                 o_busy;

   modport slave (
      input  i_req_valid, i_req_last, i_req_data0, i_req_data1, i_uart_tx_done,
      output o_req_ready, o_grant, o_uart_tx_data, o_uart_tx_ready, o_busy
   );

   modport master (
      output i_req_valid, i_req_last, i_req_data0, i_req_data1, i_uart_tx_done,
      input  o_req_ready, o_grant, o_uart_tx_data, o_uart_tx_ready, o_busy
   );

endinterface

// File: rtl/uart_tx_arbiter_tx_word_serializer.sv
// tx_word_serializer: holds the captured word, presents it MSB byte first to
// the UART and counts bytes.
//   load/load_word : capture a new word and clear the byte counter
//   send           : SEND cycle, register the top byte and raise tx_ready
//   wait_st/tx_done: WAIT cycle completion, drop tx_ready and shift the word
//   byte_done_c    : a byte completed this cycle
//   last_byte_c    : the byte in flight is the last of the word
module tx_word_serializer
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NB        = 32,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 load,
   input  logic [NB-1:0]        load_word,
   input  logic                 send,
   input  logic                 wait_st,
   input  logic                 tx_done,
   output logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 byte_done_c,
   output logic                 last_byte_c
);

   localparam int unsigned BPW = bytes_per_word(NB, DATA_BITS);
   localparam int unsigned CW  = cnt_width(BPW);

   logic [NB-1:0] word;
   logic [CW-1:0] byte_cnt;

   // Done pulses outside WAIT are ignored.
   assign byte_done_c = wait_st & tx_done;
   assign last_byte_c = (byte_cnt == CW'(BPW - 1));

   // Word shift register, byte counter and tx handshake.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         word     <= '0;
         byte_cnt <= '0;
         tx_data  <= '0;
         tx_ready <= 1'b0;
      end else begin
         if (load) begin
            word     <= load_word;
            byte_cnt <= '0;
         end
         if (send) begin
            tx_data  <= word[NB-1 -: DATA_BITS];
            tx_ready <= 1'b1;
         end
         if (byte_done_c) begin
            tx_ready <= 1'b0;
            word     <= word << DATA_BITS;
            byte_cnt <= last_byte_c ? '0 : byte_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two requesters share one UART transmitter. Words are
// granted round-robin per burst; a burst keeps the grant until its last word.
//   i_clk, i_reset : clock, synchronous active-low reset
//   bus (slave)    : requester valid/last/data and ready, grant,
//                    UART byte/ready/done, busy
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NB        = 32,
   parameter int unsigned DATA_BITS = 8
) (
   input  logic               i_clk,
   input  logic               i_reset,
   uart_tx_arbiter_if.slave   bus
);

   state_e           state;
   state_e           state_n;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] req_ready_c;
   logic             last_q;
   logic             rr_ptr;
   logic             busy_q;
   logic             sel_c;
   logic             accept_c;
   logic             burst_end_c;
   logic             byte_done_c;
   logic             last_byte_c;

   // Next state, requester selection and the combinational accept strobe.
   always_comb begin
      state_n     = state;
      req_ready_c = '0;
      sel_c       = 1'b0;
      accept_c    = 1'b0;
      burst_end_c = 1'b0;
      case (state)
         ST_IDLE: begin
            sel_c    = (&bus.i_req_valid) ? rr_ptr : bus.i_req_valid[1];
            accept_c = |bus.i_req_valid;
         end
         ST_HOLD: begin
            // Burst lock: only the current owner may continue.
            sel_c    = grant[1];
            accept_c = bus.i_req_valid[sel_c];
         end
         ST_SEND: state_n = ST_WAIT;
         ST_WAIT: begin
            if (byte_done_c) begin
               if (!last_byte_c) begin
                  state_n = ST_SEND;
               end else if (last_q) begin
                  state_n     = ST_IDLE;
                  burst_end_c = 1'b1;
               end else begin
                  state_n = ST_HOLD;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
      if (accept_c) begin
         req_ready_c[sel_c] = 1'b1;
         state_n            = ST_SEND;
      end
   end

   // State, grant, burst-last flag and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state  <= ST_IDLE;
         grant  <= '0;
         last_q <= 1'b0;
         rr_ptr <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_n;
         busy_q <= (state_n != ST_IDLE);
         if (accept_c) begin
            grant  <= N_REQ'(1) << sel_c;
            last_q <= bus.i_req_last[sel_c];
         end
         if (burst_end_c) begin
            grant  <= '0;
            rr_ptr <= ~grant[1];
         end
      end
   end

   tx_word_serializer #(
      .NB        (NB),
      .DATA_BITS (DATA_BITS)
   ) u_ser (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .load        (accept_c),
      .load_word   (sel_c ? bus.i_req_data1 : bus.i_req_data0),
      .send        (state == ST_SEND),
      .wait_st     (state == ST_WAIT),
      .tx_done     (bus.i_uart_tx_done),
      .tx_data     (bus.o_uart_tx_data),
      .tx_ready    (bus.o_uart_tx_ready),
      .byte_done_c (byte_done_c),
      .last_byte_c (last_byte_c)
   );

   assign bus.o_req_ready = req_ready_c;
   assign bus.o_grant     = grant;
   assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// bursts, checked against a burst-level arbitration model.
module tb_uart_tx_arbiter;

   localparam int unsigned NB  = 32;
   localparam int unsigned DB  = 8;
   localparam int unsigned BPW = NB / DB;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NB(NB), .DATA_BITS(DB)) bus ();

   uart_tx_arbiter #(.NB(NB), .DATA_BITS(DB)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Requester word queues (front = word currently offered).
   logic [NB-1:0] q0d[$];
   logic [NB-1:0] q1d[$];
   bit            q0l[$];
   bit            q1l[$];
   bit            gate0;

   // Observed bytes, owner at completion, low-gap before the byte.
   logic [DB-1:0] got_b[$];
   logic [1:0]    got_g[$];
   int            got_gap[$];

   // Expected stream from the model.
   logic [DB-1:0] exp_b[$];
   logic [1:0]    exp_g[$];
   bit            exp_first[$];

   int         rd;
   bit         model_ptr;
   int         done_delay;
   bit         spur;
   logic       done_auto;
   logic       done_force;
   logic [1:0] rr_last;

   assign bus.i_uart_tx_done = done_auto | done_force;

   // UART transmitter model: done a set (or random) number of cycles after ready.
   initial begin : responder
      int cnt;
      bit was_done;
      bit fire;
      cnt = -1;
      was_done = 1'b0;
      done_auto = 1'b0;
      forever begin
         @(posedge clk); #1;
         done_auto = 1'b0;
         fire = 1'b0;
         if (spur && was_done) begin
            done_auto = 1'b1;
         end else if (bus.o_uart_tx_ready) begin
            if (cnt < 0) cnt = (done_delay < 0) ? int'($urandom_range(0, 4)) : done_delay;
            if (cnt == 0) begin
               done_auto = 1'b1;
               fire = 1'b1;
               cnt = -1;
            end else begin
               cnt--;
            end
         end else begin
            cnt = -1;
         end
         was_done = fire;
      end
   end

   // Byte monitor.
   initial begin : monitor
      bit prev;
      int low_cnt;
      int pend_gap;
      prev = 1'b0;
      low_cnt = 1000;
      pend_gap = 1000;
      forever begin
         @(negedge clk);
         if (bus.o_uart_tx_ready) begin
            if (!prev) pend_gap = low_cnt;
            if (bus.i_uart_tx_done) begin
               got_b.push_back(bus.o_uart_tx_data);
               got_g.push_back(bus.o_grant);
               got_gap.push_back(pend_gap);
            end
            low_cnt = 0;
         end else begin
            low_cnt++;
         end
         prev = bus.o_uart_tx_ready;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      logic [1:0] v;
      v[0] = (q0d.size() > 0) && !gate0;
      v[1] = (q1d.size() > 0);
      bus.i_req_valid   = v;
      bus.i_req_data0   = v[0] ? q0d[0] : NB'($urandom);
      bus.i_req_data1   = v[1] ? q1d[0] : NB'($urandom);
      bus.i_req_last[0] = v[0] ? q0l[0] : 1'($urandom);
      bus.i_req_last[1] = v[1] ? q1l[0] : 1'($urandom);
   endtask

   // One clock: sample ready before the edge, retire accepted words after it.
   task automatic tick();
      @(negedge clk);
      rr_last = bus.o_req_ready;
      chk("req_ready_onehot_valid",
          64'(((rr_last & ~bus.i_req_valid) == 2'b00) && (rr_last != 2'b11)), 64'(1));
      @(posedge clk); #1;
      if (rr_last[0] && q0d.size() > 0) begin
         void'(q0d.pop_front());
         void'(q0l.pop_front());
      end
      if (rr_last[1] && q1d.size() > 0) begin
         void'(q1d.pop_front());
         void'(q1l.pop_front());
      end
      drive_inputs();
   endtask

   // Burst-level model: owner chosen by round robin when both wait, the whole
   // burst is sent, then the pointer moves to the other requester.
   task automatic model_load();
      int i0;
      int i1;
      bit w;
      bit l;
      logic [NB-1:0] word;
      i0 = 0;
      i1 = 0;
      while (i0 < q0d.size() || i1 < q1d.size()) begin
         if (i0 < q0d.size() && i1 < q1d.size()) w = model_ptr;
         else w = (i0 < q0d.size()) ? 1'b0 : 1'b1;
         do begin
            if (!w) begin
               word = q0d[i0]; l = q0l[i0]; i0++;
            end else begin
               word = q1d[i1]; l = q1l[i1]; i1++;
            end
            for (int k = 0; k < int'(BPW); k++) begin
               exp_b.push_back(DB'(word >> (NB - DB * (k + 1))));
               exp_g.push_back(w ? 2'b10 : 2'b01);
               exp_first.push_back(k == 0);
            end
         end while (!l && ((!w && i0 < q0d.size()) || (w && i1 < q1d.size())));
         model_ptr = ~w;
      end
   endtask

   task automatic wait_done(input string tag);
      int guard;
      guard = 0;
      while (!((q0d.size() == 0) && (q1d.size() == 0) && !bus.o_busy &&
               (got_b.size() >= rd + exp_b.size())) && guard < 4000) begin
         tick();
         guard++;
      end
      chk({tag, "_timeout"}, 64'(guard < 4000), 64'(1));
   endtask

   task automatic check_stream(input string tag);
      int n;
      n = got_b.size() - rd;
      chk({tag, "_len"}, 64'(n), 64'(exp_b.size()));
      for (int i = 0; i < exp_b.size() && i < n; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), 64'(got_b[rd + i]), 64'(exp_b[i]));
         chk($sformatf("%s_grant%0d", tag, i), 64'(got_g[rd + i]), 64'(exp_g[i]));
         if (!exp_first[i]) chk($sformatf("%s_gap%0d", tag, i), 64'(got_gap[rd + i]), 64'(1));
      end
      chk({tag, "_grant_idle"}, 64'(bus.o_grant), 64'(0));
      rd = got_b.size();
      exp_b.delete();
      exp_g.delete();
      exp_first.delete();
   endtask

   task automatic clear_reqs();
      q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
      gate0 = 1'b0;
      drive_inputs();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      clear_reqs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_ptr = 1'b0;
      rd = got_b.size();
      exp_b.delete(); exp_g.delete(); exp_first.delete();
   endtask

   initial begin : main
      int g;
      rst = 1'b0;
      done_force = 1'b0;
      spur = 1'b0;
      done_delay = 3;
      gate0 = 1'b0;
      rd = 0;
      model_ptr = 1'b0;
      drive_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_grant", 64'(bus.o_grant), 64'(0));
      chk("reset_tx_ready", 64'(bus.o_uart_tx_ready), 64'(0));
      chk("reset_tx_data", 64'(bus.o_uart_tx_data), 64'(0));
      chk("reset_busy", 64'(bus.o_busy), 64'(0));
      chk("reset_req_ready", 64'(bus.o_req_ready), 64'(0));
      rst = 1'b1;

      // Single word, fixed done delay, latency and one-cycle accept.
      q0d.push_back(32'hDEADBEEF); q0l.push_back(1'b1);
      model_load();
      drive_inputs();
      #1;
      chk("t1_req_ready", 64'(bus.o_req_ready), 64'(2'b01));
      tick();
      chk("t1_grant", 64'(bus.o_grant), 64'(2'b01));
      chk("t1_send_ready_low", 64'(bus.o_uart_tx_ready), 64'(0));
      chk("t1_busy", 64'(bus.o_busy), 64'(1));
      tick();
      chk("t1_req_ready_once", 64'(rr_last), 64'(0));
      chk("t1_tx_ready_n2", 64'(bus.o_uart_tx_ready), 64'(1));
      chk("t1_first_byte", 64'(bus.o_uart_tx_data), 64'(8'hDE));
      wait_done("t1");
      check_stream("t1");

      // Both valid from reset.
      apply_reset();
      done_delay = -1;
      q0d.push_back(NB'($urandom)); q0l.push_back(1'b1);
      q1d.push_back(NB'($urandom)); q1l.push_back(1'b1);
      model_load(); drive_inputs();
      wait_done("t2"); check_stream("t2");

      // Three-word burst from req0 while req1 waits.
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         q0d.push_back(NB'($urandom)); q0l.push_back(i == 2);
      end
      q1d.push_back(NB'($urandom)); q1l.push_back(1'b1);
      model_load(); drive_inputs();
      wait_done("t3"); check_stream("t3");

      // HOLD: owner pauses, other requester must not get in.
      apply_reset();
      q0d.push_back(NB'($urandom)); q0l.push_back(1'b0);
      q0d.push_back(NB'($urandom)); q0l.push_back(1'b1);
      q1d.push_back(NB'($urandom)); q1l.push_back(1'b1);
      model_load(); drive_inputs();
      g = 0;
      while (q0d.size() != 1 && g < 200) begin tick(); g++; end
      gate0 = 1'b1;
      drive_inputs();
      while ((got_b.size() - rd) < BPW && g < 400) begin tick(); g++; end
      chk("t4_reach_hold", 64'(g < 400), 64'(1));
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t4_hold_req_ready", 64'(rr_last), 64'(0));
         chk("t4_hold_tx_ready", 64'(bus.o_uart_tx_ready), 64'(0));
         chk("t4_hold_grant", 64'(bus.o_grant), 64'(2'b01));
      end
      gate0 = 1'b0;
      drive_inputs();
      wait_done("t4"); check_stream("t4");

      // Reset during WAIT of the third byte.
      apply_reset();
      done_delay = 6;
      q0d.push_back(NB'($urandom)); q0l.push_back(1'b1);
      model_load(); drive_inputs();
      g = 0;
      while (!((got_b.size() - rd) >= 2 && bus.o_uart_tx_ready) && g < 300) begin tick(); g++; end
      chk("t5_reach_byte3", 64'(g < 300), 64'(1));
      rst = 1'b0;
      clear_reqs();
      @(posedge clk); #1;
      chk("t5_rst_tx_ready", 64'(bus.o_uart_tx_ready), 64'(0));
      chk("t5_rst_grant", 64'(bus.o_grant), 64'(0));
      chk("t5_rst_busy", 64'(bus.o_busy), 64'(0));
      chk("t5_rst_tx_data", 64'(bus.o_uart_tx_data), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      model_ptr = 1'b0;
      rd = got_b.size();
      exp_b.delete(); exp_g.delete(); exp_first.delete();
      done_delay = -1;
      q0d.push_back(32'h11223344); q0l.push_back(1'b1);
      model_load(); drive_inputs();
      wait_done("t5"); check_stream("t5");

      // Spurious done in IDLE and in SEND cycles.
      spur = 1'b1;
      done_force = 1'b1;
      tick();
      done_force = 1'b0;
      q0d.push_back(32'h01020304); q0l.push_back(1'b1);
      model_load(); drive_inputs();
      wait_done("t6"); check_stream("t6");
      spur = 1'b0;

      // Random bursts on both requesters.
      for (int r = 0; r < 4; r++) begin
         for (int b = 0; b < int'($urandom_range(1, 2)); b++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < nw; w++) begin
               q0d.push_back(NB'($urandom)); q0l.push_back(w == nw - 1);
            end
         end
         for (int b = 0; b < int'($urandom_range(0, 2)); b++) begin
            int nw;
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < nw; w++) begin
               q1d.push_back(NB'($urandom)); q1l.push_back(w == nw - 1);
            end
         end
         model_load(); drive_inputs();
         wait_done($sformatf("rnd%0d", r));
         check_stream($sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
